uvmt_cv32e40x_rvfi_evt_tracker: RTL and testbench

Parametrised RVFI event tracker and sequence detector for the cv32e40x UVM/formal environment.
- Counts retirement-level events (split data transfer, push/pop, table jump, trap, table-jump exception) over NRET retirement channels with saturating counters.
- Runs an armed-window FSM that detects "event A followed by event B within WINDOW retirements".
- Bound next to the RVFI interface; outputs feed scoreboards, formal covers and end-of-test reports.

---
 rtl/uvmt_cv32e40x_rvfi_evt_pkg.sv | 36 +++
 rtl/uvmt_cv32e40x_rvfi_sat_cnt.sv | 61 ++++++
 rtl/uvmt_cv32e40x_rvfi_evt_tracker.sv | 170 +++++++++++++++++
 tb/tb_uvmt_cv32e40x_rvfi_evt_tracker.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/uvmt_cv32e40x_rvfi_evt_pkg.sv
// ----------------------------------------------------------------------------
// uvmt_cv32e40x_rvfi_evt_pkg
// Shared definitions for the RVFI event tracker:
//   - evt_e       : event index inside each channel's event-flag slice
//   - NUM_EVT     : number of tracked events per retirement channel
//   - seq_state_e : encoding of the sequence-detector state output
//   - popcount()  : population count of a (zero-extended) 32-bit vector
// ----------------------------------------------------------------------------
package uvmt_cv32e40x_rvfi_evt_pkg;

    typedef enum logic [2:0] {
        EVT_SPLIT     = 3'd0,
        EVT_PUSHPOP   = 3'd1,
        EVT_TABLEJUMP = 3'd2,
        EVT_TRAP      = 3'd3,
        EVT_TJ_EXC    = 3'd4
    } evt_e;

    localparam int unsigned NUM_EVT = 5;

    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'd0,
        SEQ_ARMED = 2'd1,
        SEQ_HIT   = 2'd2
    } seq_state_e;

    function automatic logic [5:0] popcount(input logic [31:0] vec);
        logic [5:0] cnt;
        cnt = 6'd0;
        for (int i = 0; i < 32; i++) begin
            cnt = cnt + {5'd0, vec[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/uvmt_cv32e40x_rvfi_sat_cnt.sv
// ----------------------------------------------------------------------------
// uvmt_cv32e40x_rvfi_sat_cnt
// Saturating up-counter with a sticky saturation flag.
// Ports:
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset
//   clr_i  : synchronous clear (wins over a same-cycle increment)
//   inc_i  : increment amount for this cycle
//   cnt_o  : registered count, clamps at 2^CNT_W-1
//   sat_o  : registered sticky flag, set once the count reaches its maximum
// ----------------------------------------------------------------------------
module uvmt_cv32e40x_rvfi_sat_cnt #(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned INC_W = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic [INC_W-1:0] inc_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             sat_o
);

    // Three guard bits keep the sum of count and increment from wrapping.
    localparam int unsigned      SUM_W   = CNT_W + 3;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sat_q, sat_d;
    logic [SUM_W-1:0] sum_s;

    // Next-state: clear, clamp at maximum, or plain add.
    always_comb begin
        sum_s = SUM_W'(cnt_q) + SUM_W'(inc_i);
        if (clr_i) begin
            cnt_d = {CNT_W{1'b0}};
            sat_d = 1'b0;
        end else if (sum_s >= SUM_W'(CNT_MAX)) begin
            cnt_d = CNT_MAX;
            sat_d = 1'b1;
        end else begin
            cnt_d = sum_s[CNT_W-1:0];
            sat_d = sat_q;
        end
    end

    // Count and sticky flag registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= {CNT_W{1'b0}};
            sat_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sat_q <= sat_d;
        end
    end

    assign cnt_o = cnt_q;
    assign sat_o = sat_q;

endmodule

// File: rtl/uvmt_cv32e40x_rvfi_evt_tracker.sv
// ----------------------------------------------------------------------------
// uvmt_cv32e40x_rvfi_evt_tracker
// Counts qualified RVFI retirement events per event type (saturating) and
// detects "ARM_EVT followed by TGT_EVT within WINDOW retirements".
// Ports:
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   clr_i          : synchronous clear of counters and sequence FSM
//   rvfi_valid_i   : per-channel retirement valid (index 0 = oldest)
//   evt_i          : per-channel event flags, channel c at [c*NUM_EVT +: NUM_EVT]
//   cnt_o, sat_o   : per-event saturating counts and sticky saturation flags
//   seq_state_o    : sequence FSM state (seq_state_e)
//   seq_hit_o      : one-cycle pulse while the FSM sits in HIT
//   seq_hit_cnt_o  : saturating count of sequence hits
// Optional: define UVMT_CV32E40X_RVFI_EVT_COVER_EN to compile cover
// properties and assertions; ports and logic are unchanged either way.
// ----------------------------------------------------------------------------
module uvmt_cv32e40x_rvfi_evt_tracker
    import uvmt_cv32e40x_rvfi_evt_pkg::*;
#(
    parameter int unsigned NRET    = 1,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned WINDOW  = 4,
    parameter int unsigned ARM_EVT = 1,   // EVT_PUSHPOP
    parameter int unsigned TGT_EVT = 3    // EVT_TRAP
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clr_i,
    input  logic [NRET-1:0]          rvfi_valid_i,
    input  logic [NRET*NUM_EVT-1:0]  evt_i,
    output logic [NUM_EVT*CNT_W-1:0] cnt_o,
    output logic [NUM_EVT-1:0]       sat_o,
    output logic [1:0]               seq_state_o,
    output logic                     seq_hit_o,
    output logic [CNT_W-1:0]         seq_hit_cnt_o
);

    localparam logic [1:0] ST_IDLE  = SEQ_IDLE;
    localparam logic [1:0] ST_ARMED = SEQ_ARMED;
    localparam logic [1:0] ST_HIT   = SEQ_HIT;
    localparam int unsigned INC_W   = 3;
    localparam logic [8:0]  WIN_LIM = 9'(WINDOW);

    logic [NUM_EVT-1:0][NRET-1:0]  qual_s;
    logic [NUM_EVT-1:0][INC_W-1:0] inc_s;
    logic [1:0] state_q, state_d;
    logic [8:0] win_q, win_d;
    logic       hit_q;
    logic       armed_v, hit_v;
    logic [8:0] win_v;
    logic       unused_hit_sat_s;

    // Qualify each event flag with its channel valid and count per event.
    always_comb begin
        for (int e = 0; e < NUM_EVT; e++) begin
            for (int c = 0; c < NRET; c++) begin
                qual_s[e][c] = rvfi_valid_i[c] & evt_i[c*NUM_EVT + e];
            end
            inc_s[e] = INC_W'(popcount(32'(qual_s[e])));
        end
    end

    for (genvar e = 0; e < NUM_EVT; e++) begin : g_cnt
        uvmt_cv32e40x_rvfi_sat_cnt #(.CNT_W(CNT_W), .INC_W(INC_W)) u_cnt (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .clr_i  (clr_i),
            .inc_i  (inc_s[e]),
            .cnt_o  (cnt_o[e*CNT_W +: CNT_W]),
            .sat_o  (sat_o[e])
        );
    end

    // Walk channels oldest to youngest. A retirement first advances an open
    // window (and may complete it), then may (re)arm; so an instruction that is
    // both ARM and TGT cannot hit itself. No hit is taken during the HIT cycle
    // so the pulse stays one cycle wide.
    always_comb begin
        armed_v = (state_q == ST_ARMED);
        win_v   = win_q;
        hit_v   = 1'b0;
        for (int c = 0; c < NRET; c++) begin
            if (rvfi_valid_i[c]) begin
                if (armed_v) begin
                    win_v = win_v + 9'd1;
                    if (win_v > WIN_LIM) begin
                        armed_v = 1'b0;
                    end else if (qual_s[TGT_EVT][c] && (state_q != ST_HIT)) begin
                        hit_v   = 1'b1;
                        armed_v = 1'b0;
                    end else begin
                        armed_v = 1'b1;
                    end
                end else begin
                    armed_v = 1'b0;
                end
                if (qual_s[ARM_EVT][c]) begin
                    armed_v = 1'b1;
                    win_v   = 9'd0;
                end else begin
                    win_v   = win_v;
                end
            end else begin
                win_v = win_v;
            end
        end

        if (clr_i) begin
            state_d = ST_IDLE;
            win_d   = 9'd0;
        end else if (hit_v) begin
            state_d = ST_HIT;
            win_d   = 9'd0;
        end else if (armed_v) begin
            state_d = ST_ARMED;
            win_d   = win_v;
        end else begin
            state_d = ST_IDLE;
            win_d   = 9'd0;
        end
    end

    // Sequence FSM state, window counter and hit pulse registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            win_q   <= 9'd0;
            hit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            hit_q   <= (state_d == ST_HIT);
        end
    end

    // The hit count advances together with the pulse it counts.
    uvmt_cv32e40x_rvfi_sat_cnt #(.CNT_W(CNT_W), .INC_W(1)) u_hit_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (clr_i),
        .inc_i  (state_d == ST_HIT),
        .cnt_o  (seq_hit_cnt_o),
        .sat_o  (unused_hit_sat_s)
    );

    assign seq_state_o = state_q;
    assign seq_hit_o   = hit_q;

`ifdef UVMT_CV32E40X_RVFI_EVT_COVER_EN
    for (genvar e = 0; e < NUM_EVT; e++) begin : g_prop
        cov_cnt_one: cover property (@(posedge clk_i) disable iff (!rst_ni)
            cnt_o[e*CNT_W +: CNT_W] == CNT_W'(1));
        cov_sat_rise: cover property (@(posedge clk_i) disable iff (!rst_ni)
            $rose(sat_o[e]));
        ast_cnt_mono: assert property (@(posedge clk_i) disable iff (!rst_ni)
            !clr_i |=> (cnt_o[e*CNT_W +: CNT_W] >= $past(cnt_o[e*CNT_W +: CNT_W])));
    end
    cov_seq_hit: cover property (@(posedge clk_i) disable iff (!rst_ni) seq_hit_o);
    cov_expiry: cover property (@(posedge clk_i) disable iff (!rst_ni)
        (state_q == ST_ARMED && !clr_i) ##1 (state_q == ST_IDLE));
    if (NRET > 1) begin : g_same_cycle
        // From IDLE, HIT can only follow an arm and target in the same cycle.
        cov_same_cycle_hit: cover property (@(posedge clk_i) disable iff (!rst_ni)
            (state_q == ST_IDLE) && (state_d == ST_HIT));
    end
    ast_hit_pulse: assert property (@(posedge clk_i) disable iff (!rst_ni)
        seq_hit_o |=> !seq_hit_o);
`endif

endmodule

// File: tb/tb_uvmt_cv32e40x_rvfi_evt_tracker.sv
// Directed bench: dut1 is NRET=1/CNT_W=4/WINDOW=4, dut2 is NRET=2/CNT_W=16/WINDOW=4.
module tb_uvmt_cv32e40x_rvfi_evt_tracker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic [0:0]  v1 = 1'b0;
    logic [4:0]  e1 = 5'd0;
    logic [1:0]  v2 = 2'd0;
    logic [9:0]  e2 = 10'd0;

    logic [19:0] cnt1;
    logic [4:0]  sat1;
    logic [1:0]  st1;
    logic        hit1;
    logic [3:0]  hcnt1;
    logic [79:0] cnt2;
    logic [4:0]  sat2;
    logic [1:0]  st2;
    logic        hit2;
    logic [15:0] hcnt2;

    int checks = 0;
    int failures = 0;

    localparam logic [4:0] E_SPLIT = 5'b00001;
    localparam logic [4:0] E_PP    = 5'b00010;
    localparam logic [4:0] E_TRAP  = 5'b01000;

    always #5 clk = ~clk;

    uvmt_cv32e40x_rvfi_evt_tracker #(.NRET(1), .CNT_W(4), .WINDOW(4)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .rvfi_valid_i(v1), .evt_i(e1),
        .cnt_o(cnt1), .sat_o(sat1), .seq_state_o(st1), .seq_hit_o(hit1),
        .seq_hit_cnt_o(hcnt1));

    uvmt_cv32e40x_rvfi_evt_tracker #(.NRET(2), .CNT_W(16), .WINDOW(4)) dut2 (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .rvfi_valid_i(v2), .evt_i(e2),
        .cnt_o(cnt2), .sat_o(sat2), .seq_state_o(st2), .seq_hit_o(hit2),
        .seq_hit_cnt_o(hcnt2));

    task automatic check_val(input string tag, input int unsigned obs, input int unsigned exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int unsigned c1(input int e);
        return int'(cnt1[e*4 +: 4]);
    endfunction

    function automatic int unsigned c2(input int e);
        return int'(cnt2[e*16 +: 16]);
    endfunction

    // One clock with the given inputs; returns 1 time unit after the edge.
    task automatic step(input logic vv1, input logic [4:0] ee1, input logic [1:0] vv2,
                        input logic [9:0] ee2, input logic cc);
        v1 = vv1; e1 = ee1; v2 = vv2; e2 = ee2; clr = cc;
        @(posedge clk);
        #1;
        v1 = 1'b0; e1 = 5'd0; v2 = 2'd0; e2 = 10'd0; clr = 1'b0;
    endtask

    task automatic ret1(input logic [4:0] ee1);
        step(1'b1, ee1, 2'd0, 10'd0, 1'b0);
    endtask

    initial begin
        #3;
        check_val("rst_cnt", int'(cnt1), 0);
        check_val("rst_sat", int'(sat1), 0);
        check_val("rst_state", int'(st1), 0);
        check_val("rst_hit", int'(hit1), 0);
        check_val("rst_hitcnt", int'(hcnt1), 0);
        #9 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Three pushpops then clear coincident with a fourth.
        for (int i = 1; i <= 3; i++) begin
            ret1(E_PP);
            check_val("pp_cnt", c1(1), i);
        end
        step(1'b1, E_PP, 2'd0, 10'd0, 1'b1);
        check_val("clr_cnt", c1(1), 0);
        check_val("clr_state", int'(st1), 0);

        // Saturation of a 4-bit counter.
        for (int i = 1; i <= 17; i++) begin
            ret1(E_SPLIT);
            if (i == 14) begin
                check_val("split14_cnt", c1(0), 14);
                check_val("split14_sat", int'(sat1[0]), 0);
            end
            if (i == 15) begin
                check_val("split15_cnt", c1(0), 15);
                check_val("split15_sat", int'(sat1[0]), 1);
            end
        end
        check_val("split17_cnt", c1(0), 15);
        check_val("split17_sat", int'(sat1[0]), 1);

        // Hit at exactly WINDOW retirements.
        ret1(E_PP);
        check_val("arm_state", int'(st1), 1);
        for (int i = 0; i < 3; i++) ret1(5'd0);
        ret1(E_TRAP);
        check_val("win_hit", int'(hit1), 1);
        check_val("win_hit_state", int'(st1), 2);
        check_val("win_hitcnt", int'(hcnt1), 1);
        ret1(5'd0);
        check_val("hit_pulse_end", int'(hit1), 0);
        check_val("hit_to_idle", int'(st1), 0);

        // Five plain retirements expire the window.
        ret1(E_PP);
        for (int i = 0; i < 5; i++) ret1(5'd0);
        check_val("expire_state", int'(st1), 0);
        ret1(E_TRAP);
        check_val("expire_nohit", int'(hit1), 0);

        // Four plain retirements: still armed, trap is the fifth -> no hit.
        ret1(E_PP);
        for (int i = 0; i < 4; i++) ret1(5'd0);
        check_val("edge_armed", int'(st1), 1);
        ret1(E_TRAP);
        check_val("edge_nohit", int'(hit1), 0);
        check_val("edge_idle", int'(st1), 0);
        check_val("edge_hitcnt", int'(hcnt1), 1);

        // NRET=2 intra-cycle ordering.
        step(1'b0, 5'd0, 2'b11, 10'h102, 1'b0);
        check_val("same_cyc_hit", int'(hit2), 1);
        check_val("same_cyc_state", int'(st2), 2);
        step(1'b0, 5'd0, 2'b00, 10'h000, 1'b0);
        check_val("same_cyc_idle", int'(st2), 0);
        step(1'b0, 5'd0, 2'b11, 10'h048, 1'b0);
        check_val("rev_nohit", int'(hit2), 0);
        check_val("rev_armed", int'(st2), 1);
        step(1'b0, 5'd0, 2'b00, 10'h3FF, 1'b0);
        check_val("inval_pp", c2(1), 2);
        check_val("inval_trap", c2(3), 2);
        check_val("inval_state", int'(st2), 1);

        // Idle cycles do not expire the window.
        ret1(E_PP);
        for (int i = 0; i < 20; i++) step(1'b0, E_TRAP, 2'd0, 10'd0, 1'b0);
        check_val("idle_armed", int'(st1), 1);
        ret1(E_TRAP);
        check_val("idle_hit", int'(hit1), 1);
        check_val("idle_hitcnt", int'(hcnt1), 2);

        // Asynchronous reset while armed.
        step(1'b0, 5'd0, 2'd0, 10'd0, 1'b1);
        for (int i = 0; i < 7; i++) ret1(E_PP);
        check_val("pre_rst_cnt", c1(1), 7);
        check_val("pre_rst_state", int'(st1), 1);
        #2 rst_n = 1'b0;
        #1;
        check_val("arst_cnt", int'(cnt1), 0);
        check_val("arst_state", int'(st1), 0);
        check_val("arst_hitcnt", int'(hcnt1), 0);
        check_val("arst_sat", int'(sat1), 0);
        #1 rst_n = 1'b1;
        ret1(E_TRAP);
        check_val("post_rst_nohit", int'(hit1), 0);
        check_val("post_rst_state", int'(st1), 0);
        check_val("post_rst_trap", c1(3), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
